// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO and the UART transmitter that drains it.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO; writes are dropped when full, pops when empty.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  // One extra pointer bit distinguishes full from empty.
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign empty   = (r_wptr == r_rptr);
  assign full    = (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]) &&
                   (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);
  assign w_wr_en = wr && !full;
  assign w_rd_en = rd && !empty;
  assign r_data  = r_mem[r_rptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= w_data;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a FWFT FIFO: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

  localparam logic [CntW-1:0] CntLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntPenult = CntW'(CLKS_PER_BIT - 2);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  logic [CntW-1:0]       r_cnt;
  logic [IdxW-1:0]       r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_done;
  logic                  w_bit_end;

  assign rd           = (r_state == StIdle) && !empty && !reset;
  assign busy         = (r_state != StIdle);
  assign tx           = r_tx;
  assign tx_done_tick = r_done;
  assign w_bit_end    = (r_cnt == CntLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      // Registered tick, so it is raised one cycle ahead to land on the last stop cycle.
      r_done <= (r_state == StStop) && (r_cnt == CntPenult);
      unique case (r_state)
        StIdle: begin
          if (rd) begin
            r_shift <= r_data;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_state <= StData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_idx == IdxLast) begin
              r_tx    <= 1'b1;
              r_state <= StStop;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench pairing fifo_uart_tx with an 8x8 FIFO; a frame-position model plus directed scenarios.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int CPB = 4;
  localparam int L   = (DW + 2) * CPB;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       fifo_rst = 1'b1;
  logic       wr       = 1'b0;
  logic [7:0] w_data   = 8'd0;
  logic       empty;
  logic       full;
  logic [7:0] r_data;
  logic       rd;
  logic       tx;
  logic       busy;
  logic       done;

  fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_fifo (
    .clk   (clk),
    .reset (fifo_rst),
    .wr    (wr),
    .rd    (rd),
    .w_data(w_data),
    .empty (empty),
    .full  (full),
    .r_data(r_data)
  );

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .r_data      (r_data),
    .rd          (rd),
    .tx          (tx),
    .busy        (busy),
    .tx_done_tick(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wr_cyc = 0;
  int rd_q[$];
  int done_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  // Model: position within the current frame (0 = idle) and a queue of FIFO contents.
  int         mpos = 0;
  logic [7:0] mcur = 8'd0;
  logic [7:0] m_q[$];
  logic       exp_rd;
  logic       exp_tx;
  int         k;
  int         pre;

  logic       rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'd0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    done_q.delete();
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic put(input logic [7:0] b);
    wr     = 1'b1;
    w_data = b;
    tick();
    wr     = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (busy === 1'b0 && empty === 1'b1) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_timeout: busy %b empty %b, required idle within %0d cycles",
               nm, busy, empty, maxc);
    end
    repeat (2) tick();
  endtask

  task automatic chk_rx(input string nm);
    chkn({nm, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chkn({nm, "_byte"}, int'(rx_q[i]), int'(exp_q[i]));
  endtask

  // Per-cycle compare against the model, then advance it with the inputs the next edge samples.
  initial begin
    @(negedge clk);
    forever begin
      exp_rd = (mpos == 0) && (m_q.size() > 0) && !reset;
      k = (mpos - 1) / CPB;
      if (mpos == 0)    exp_tx = 1'b1;
      else if (k == 0)  exp_tx = 1'b0;
      else if (k <= DW) exp_tx = mcur[k-1];
      else              exp_tx = 1'b1;
      chk1("rd", rd, exp_rd);
      chk1("tx", tx, exp_tx);
      chk1("busy", busy, mpos != 0);
      chk1("done", done, mpos == L);
      chk1("empty", empty, m_q.size() == 0);
      chk1("full", full, m_q.size() == (1 << AW));
      if (rd === 1'b1 && empty === 1'b1) chk1("rd_while_empty", rd, 1'b0);
      if (rd === 1'b1) rd_q.push_back(cyc);
      if (done === 1'b1) done_q.push_back(cyc);
      if (wr) wr_cyc = cyc;
      pre = m_q.size();
      if (reset) mpos = 0;
      else if (exp_rd) begin
        mcur = m_q[0];
        mpos = 1;
      end else if (mpos == L) mpos = 0;
      else if (mpos != 0) mpos++;
      if (fifo_rst) m_q.delete();
      else begin
        if (exp_rd) void'(m_q.pop_front());
        if (wr && pre < (1 << AW)) m_q.push_back(w_data);
      end
      cyc++;
      @(negedge clk);
    end
  end

  // Independent line receiver: samples the second cycle of each bit after the start edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) rx_on = 1'b0;
      else if (!rx_on) begin
        if (tx === 1'b0) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == (DW + 1) * CPB + 1) begin
          rx_on = 1'b0;
          if (tx === 1'b1) rx_q.push_back(rx_byte);
        end else if (rx_cnt % CPB == 1 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= DW) begin
          rx_byte[rx_cnt/CPB-1] = tx;
        end
      end
    end
  end

  initial begin
    logic [9:0] pat;
    int rel_cyc;

    repeat (2) tick();
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rd", rd, 1'b0);
    chk1("rst_done", done, 1'b0);
    reset    = 1'b0;
    fifo_rst = 1'b0;
    tick();

    // Single byte 5: start, 1,0,1,0,0,0,0,0, stop.
    clear_logs();
    pat = 10'b1000001010;
    put(8'd5);
    chk1("s1_rd", rd, 1'b1);
    for (int p = 1; p <= L; p++) begin
      tick();
      chk1("s1_tx", tx, pat[(p-1)/CPB]);
      if (p == L) chk1("s1_done", done, 1'b1);
    end
    tick();
    chk1("s1_busy_fall", busy, 1'b0);
    repeat (2) tick();
    chkn("s1_rd_pulses", rd_q.size(), 1);
    if (rd_q.size() == 1 && done_q.size() == 1)
      chkn("s1_latency", done_q[0] - rd_q[0], 40);
    exp_q.push_back(8'd5);
    chk_rx("s1_rx");

    // Idle with nothing written.
    clear_logs();
    for (int i = 0; i < 200; i++) begin
      tick();
      chk1("s2_tx", tx, 1'b1);
      chk1("s2_rd", rd, 1'b0);
      chk1("s2_busy", busy, 1'b0);
    end
    chkn("s2_rd_pulses", rd_q.size(), 0);
    chkn("s2_rx_count", rx_q.size(), 0);

    // Back-to-back frames.
    clear_logs();
    put(8'd12);
    put(8'd2);
    put(8'd9);
    wait_idle("s3", 3 * (L + 1) + 50);
    chkn("s3_rd_pulses", rd_q.size(), 3);
    if (rd_q.size() == 3) begin
      chkn("s3_gap01", rd_q[1] - rd_q[0], 41);
      chkn("s3_gap12", rd_q[2] - rd_q[1], 41);
    end
    exp_q.push_back(8'd12);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd9);
    chk_rx("s3_rx");

    // Full FIFO: transmitter held in reset while all eight words go in.
    clear_logs();
    reset = 1'b1;
    tick();
    put(8'd5);
    put(8'd8);
    put(8'd12);
    put(8'd2);
    put(8'd9);
    put(8'd14);
    put(8'd13);
    put(8'd6);
    chk1("s4_full", full, 1'b1);
    reset   = 1'b0;
    rel_cyc = cyc;
    wait_idle("s4", 8 * (L + 1) + 50);
    chkn("s4_rd_pulses", rd_q.size(), 8);
    if (rd_q.size() > 0) chkn("s4_first_rd", rd_q[0], rel_cyc);
    chk1("s4_empty_end", empty, 1'b1);
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd8);
    exp_q.push_back(8'd12);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd9);
    exp_q.push_back(8'd14);
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd6);
    chk_rx("s4_rx");

    // Reset during data bit 3 of A5, then a clean 3C frame.
    clear_logs();
    put(8'hA5);
    repeat (18) tick();
    chk1("s5_pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("s5_tx_after_reset", tx, 1'b1);
    chk1("s5_busy_after_reset", busy, 1'b0);
    chk1("s5_empty_after_reset", empty, 1'b1);
    tick();
    put(8'h3C);
    wait_idle("s5", L + 50);
    chkn("s5_rd_pulses", rd_q.size(), 2);
    exp_q.push_back(8'h3C);
    chk_rx("s5_rx");

    // Write into an empty FIFO while idle: pop follows the cycle empty falls.
    clear_logs();
    repeat (3) tick();
    put(8'd17);
    wait_idle("s6", L + 50);
    chkn("s6_rd_pulses", rd_q.size(), 1);
    if (rd_q.size() == 1) chkn("s6_rd_cycle", rd_q[0], wr_cyc + 1);
    exp_q.push_back(8'd17);
    chk_rx("s6_rx");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
